// File: rtl/sd_crc_pkg.sv
// Purpose: shared types, default polynomials and the serial CRC step for the SD CRC engine.
// Latency: combinational helpers only, no state.
// Backpressure: none; bit pacing is set by the users of crc_step.
//
// Contents:
//   CRC16_POLY_DEFAULT / CRC7_POLY_DEFAULT  polynomials without the top x^n term
//   dat_state_e / cmd_state_e               data and CMD sequencer states
//   crc_step(width, crc, din, poly)         one MSB-first serial CRC update, width <= 16
package sd_crc_pkg;

  localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h1021;
  localparam logic [6:0]  CRC7_POLY_DEFAULT  = 7'h09;
  localparam int unsigned CRC16_W            = 16;
  localparam int unsigned CRC7_W             = 7;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_EMIT  = 2'd1,
    D_END   = 2'd2,
    D_CHECK = 2'd3
  } dat_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_EMIT = 2'd1,
    C_END  = 2'd2
  } cmd_state_e;

  // Narrow CRCs live right-aligned in the 16-bit container; the mask keeps
  // the shifted-out top bit from leaking above the register width.
  function automatic logic [15:0] crc_step(input int unsigned width,
                                           input logic [15:0]  crc,
                                           input logic         din,
                                           input logic [15:0]  poly);
    logic [15:0] msb_mask;
    logic [15:0] mask;
    logic        fb;
    msb_mask = 16'h0001 << (width - 1);
    mask     = msb_mask | (msb_mask - 16'h0001);
    fb       = din ^ (|(crc & msb_mask));
    return ((crc << 1) ^ (fb ? poly : 16'h0000)) & mask;
  endfunction

endpackage

// File: rtl/sd_crc_lane.sv
// Purpose: one DAT-lane CRC16 register with absorb, zero-fill shift-out and compare.
// Latency: register updates on the clock after a qualified strobe; outputs are flop values.
// Backpressure: none; the parent only raises controls on bit-strobe cycles.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   clr_i                 synchronous clear of CRC and error flag (highest priority)
//   absorb_i              fold dat_i into the CRC
//   shift_i               shift the CRC left with zero fill (emit or check)
//   cmp_i                 compare dat_i with the outgoing MSB, sticky error on mismatch
//   err_clr_i             clear the sticky error at the start of a check
//   dat_i                 serial lane bit
//   crc_o, err_o          CRC register and sticky mismatch flag
module sd_crc_lane
  import sd_crc_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        absorb_i,
  input  logic        shift_i,
  input  logic        cmp_i,
  input  logic        err_clr_i,
  input  logic        dat_i,
  output logic [15:0] crc_o,
  output logic        err_o
);

  logic [15:0] crc_q, crc_d;
  logic        err_q, err_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)         crc_d = 16'h0000;
    else if (absorb_i) crc_d = crc_step(CRC16_W, crc_q, dat_i, POLY);
    else if (shift_i)  crc_d = {crc_q[14:0], 1'b0};
  end

  always_comb begin
    err_d = err_q;
    if (clr_i)          err_d = 1'b0;
    else if (err_clr_i) err_d = 1'b0;
    else if (cmp_i)     err_d = err_q | (dat_i ^ crc_q[15]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 16'h0000;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end

  assign crc_o = crc_q;
  assign err_o = err_q;

endmodule

// File: rtl/sd_crc_engine.sv
// Purpose: SD-bus CRC unit: per-lane CRC16 plus CMD CRC7, with emit and check sequencing.
// Latency: oe rises 1 clk after an emit request; chk_done pulses 1 clk after the last checked bit.
// Backpressure: none; requests and absorb enables are ignored while the owning FSM is busy.
//
// Ports:
//   clk_i, rst_i, clken_i, clr_i           clock, async reset, bit strobe, sync clear
//   dat_i/dat_en_i/dat_emit_i/dat_check_i  DAT lane bits, absorb enable, emit and check requests
//   dat_o/dat_oe_o/dat_busy_o              emitted DAT bits, drive enable, data FSM busy
//   dat_err_o/dat_chk_done_o               sticky per-lane mismatch, end-of-check pulse
//   cmd_i/cmd_en_i/cmd_emit_i              CMD bit, absorb enable, emit request
//   cmd_o/cmd_oe_o/cmd_busy_o              emitted CMD bit, drive enable, CMD FSM busy
//   crc16_o/crc7_o                         raw CRC registers, lane l at [16l+15:16l]
module sd_crc_engine
  import sd_crc_pkg::*;
#(
  parameter int unsigned LANES      = 4,  // 1, 4 or 8
  parameter logic [15:0] CRC16_POLY = CRC16_POLY_DEFAULT,
  parameter logic [6:0]  CRC7_POLY  = CRC7_POLY_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clken_i,
  input  logic                  clr_i,
  input  logic [LANES-1:0]      dat_i,
  input  logic                  dat_en_i,
  input  logic                  dat_emit_i,
  input  logic                  dat_check_i,
  output logic [LANES-1:0]      dat_o,
  output logic                  dat_oe_o,
  output logic                  dat_busy_o,
  output logic [LANES-1:0]      dat_err_o,
  output logic                  dat_chk_done_o,
  input  logic                  cmd_i,
  input  logic                  cmd_en_i,
  input  logic                  cmd_emit_i,
  output logic                  cmd_o,
  output logic                  cmd_oe_o,
  output logic                  cmd_busy_o,
  output logic [16*LANES-1:0]   crc16_o,
  output logic [6:0]            crc7_o
);

  // ---------------- data path state ----------------
  dat_state_e       dat_state_q, dat_state_d;
  logic [3:0]       dat_cnt_q, dat_cnt_d;
  logic             chk_done_q, chk_done_d;

  logic             lane_absorb, lane_shift, lane_cmp, lane_err_clr;
  logic [LANES-1:0] lane_msb;

  // ---------------- CMD path state ----------------
  cmd_state_e       cmd_state_q, cmd_state_d;
  logic [2:0]       cmd_cnt_q, cmd_cnt_d;
  logic [6:0]       crc7_q, crc7_d;
  logic             cmd_absorb, cmd_shift;

  // ---------------- lanes ----------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sd_crc_lane #(.POLY(CRC16_POLY)) u_lane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .absorb_i  (lane_absorb),
      .shift_i   (lane_shift),
      .cmp_i     (lane_cmp),
      .err_clr_i (lane_err_clr),
      .dat_i     (dat_i[l]),
      .crc_o     (crc16_o[16*l +: 16]),
      .err_o     (dat_err_o[l])
    );
    assign lane_msb[l] = crc16_o[16*l + 15];
  end

  // ---------------- data FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_state_q <= D_IDLE;
      dat_cnt_q   <= 4'd0;
      chk_done_q  <= 1'b0;
    end else begin
      dat_state_q <= dat_state_d;
      dat_cnt_q   <= dat_cnt_d;
      chk_done_q  <= chk_done_d;
    end
  end

  // ---------------- data FSM: next state ----------------
  // Requests are sampled every clk; only bit movement waits for clken_i.
  always_comb begin
    dat_state_d = dat_state_q;
    dat_cnt_d   = dat_cnt_q;
    chk_done_d  = 1'b0;
    if (clr_i) begin
      dat_state_d = D_IDLE;
      dat_cnt_d   = 4'd0;
    end else begin
      unique case (dat_state_q)
        D_IDLE: begin
          if (dat_emit_i) begin
            dat_state_d = D_EMIT;
            dat_cnt_d   = 4'd15;
          end else if (dat_check_i) begin
            dat_state_d = D_CHECK;
            dat_cnt_d   = 4'd15;
          end
        end
        D_EMIT: begin
          if (clken_i) begin
            if (dat_cnt_q == 4'd0) dat_state_d = D_END;
            else                   dat_cnt_d   = dat_cnt_q - 4'd1;
          end
        end
        D_END: begin
          if (clken_i) dat_state_d = D_IDLE;
        end
        D_CHECK: begin
          if (clken_i) begin
            if (dat_cnt_q == 4'd0) begin
              dat_state_d = D_IDLE;
              chk_done_d  = 1'b1;
            end else begin
              dat_cnt_d = dat_cnt_q - 4'd1;
            end
          end
        end
        default: dat_state_d = D_IDLE;
      endcase
    end
  end

  // ---------------- data FSM: outputs ----------------
  always_comb begin
    dat_oe_o    = 1'b0;
    dat_o       = '0;
    lane_absorb = 1'b0;
    lane_shift  = 1'b0;
    lane_cmp    = 1'b0;
    unique case (dat_state_q)
      D_IDLE:  lane_absorb = dat_en_i & clken_i;
      D_EMIT: begin
        dat_oe_o   = 1'b1;
        dat_o      = lane_msb;
        lane_shift = clken_i;
      end
      D_END: begin
        dat_oe_o = 1'b1;
        dat_o    = '1;
      end
      D_CHECK: begin
        lane_shift = clken_i;
        lane_cmp   = clken_i;
      end
      default: ;
    endcase
  end

  // Errors restart only when a check actually begins (emit wins a tie).
  assign lane_err_clr   = (dat_state_q == D_IDLE) & ~dat_emit_i & dat_check_i;
  assign dat_busy_o     = (dat_state_q != D_IDLE);
  assign dat_chk_done_o = chk_done_q;

  // ---------------- CMD FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_state_q <= C_IDLE;
      cmd_cnt_q   <= 3'd0;
      crc7_q      <= 7'd0;
    end else begin
      cmd_state_q <= cmd_state_d;
      cmd_cnt_q   <= cmd_cnt_d;
      crc7_q      <= crc7_d;
    end
  end

  // ---------------- CMD FSM: next state ----------------
  always_comb begin
    cmd_state_d = cmd_state_q;
    cmd_cnt_d   = cmd_cnt_q;
    if (clr_i) begin
      cmd_state_d = C_IDLE;
      cmd_cnt_d   = 3'd0;
    end else begin
      unique case (cmd_state_q)
        C_IDLE: begin
          if (cmd_emit_i) begin
            cmd_state_d = C_EMIT;
            cmd_cnt_d   = 3'd6;
          end
        end
        C_EMIT: begin
          if (clken_i) begin
            if (cmd_cnt_q == 3'd0) cmd_state_d = C_END;
            else                   cmd_cnt_d   = cmd_cnt_q - 3'd1;
          end
        end
        C_END: begin
          if (clken_i) cmd_state_d = C_IDLE;
        end
        default: cmd_state_d = C_IDLE;
      endcase
    end
  end

  // ---------------- CMD FSM: outputs ----------------
  always_comb begin
    cmd_oe_o   = 1'b0;
    cmd_o      = 1'b0;
    cmd_absorb = 1'b0;
    cmd_shift  = 1'b0;
    unique case (cmd_state_q)
      C_IDLE: cmd_absorb = cmd_en_i & clken_i;
      C_EMIT: begin
        cmd_oe_o  = 1'b1;
        cmd_o     = crc7_q[6];
        cmd_shift = clken_i;
      end
      C_END: begin
        cmd_oe_o = 1'b1;
        cmd_o    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    crc7_d = crc7_q;
    if (clr_i)           crc7_d = 7'd0;
    else if (cmd_absorb) crc7_d = 7'(crc_step(CRC7_W, {9'd0, crc7_q}, cmd_i, {9'd0, CRC7_POLY}));
    else if (cmd_shift)  crc7_d = {crc7_q[5:0], 1'b0};
  end

  assign cmd_busy_o = (cmd_state_q != C_IDLE);
  assign crc7_o     = crc7_q;

endmodule

// File: doc/sd_crc_engine.md
Name: sd_crc_engine

Overview:
- Multi-lane SD-bus CRC unit: one serial CRC16 per DAT lane plus one CRC7 for the CMD line.
- Beyond plain accumulation, it sequences CRC emission (CRC bits MSB first, then end bit) and CRC checking against received bits, with per-lane sticky error flags.
- Sits between the SD bit-serialiser/deserialiser and the SD host controller FSM; all bit activity is qualified by the controller's bit strobe clken_i.

Parameters:
- LANES, 4, number of DAT lanes (legal values 1, 4, 8).
- CRC16_POLY, 16'h1021, CRC16 polynomial without the x^16 term.
- CRC7_POLY, 7'h09, CRC7 polynomial without the x^7 term.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- clken_i  in  1  bit strobe; all CRC/shift/counter activity occurs only on cycles where it is high.
- clr_i  in  1  synchronous clear of all CRCs, error flags and FSMs.
- dat_i  in  LANES  serial data bits, one per lane.
- dat_en_i  in  1  absorb dat_i into the CRC16s (D_IDLE only).
- dat_emit_i  in  1  request emission of the CRC16s plus end bit.
- dat_check_i  in  1  request checking of the next 16 dat_i bits against the CRC16s.
- dat_o  out  LANES  emitted bits.
- dat_oe_o  out  1  dat_o valid, drive the lanes.
- dat_busy_o  out  1  data FSM not idle.
- dat_err_o  out  LANES  sticky per-lane CRC mismatch flags.
- dat_chk_done_o  out  1  one-clk pulse at the end of a check.
- cmd_i  in  1  serial CMD bit.
- cmd_en_i  in  1  absorb cmd_i into the CRC7 (C_IDLE only).
- cmd_emit_i  in  1  request emission of the CRC7 plus end bit.
- cmd_o  out  1  emitted CMD bit.
- cmd_oe_o  out  1  cmd_o valid.
- cmd_busy_o  out  1  CMD FSM not idle.
- crc16_o  out  16*LANES  CRC16 registers; lane l occupies [16l+15:16l].
- crc7_o  out  7  CRC7 register.

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. Reset clears all CRCs, dat_err_o, counters and outputs to 0, and puts both FSMs in IDLE.
- clr_i: same effect as reset, but synchronous. It takes priority over every other input and aborts any emission or check in progress without generating dat_chk_done_o.
- Update rule, per lane, on clken_i with absorb enabled:
  - fb = dat_i[l] ^ crc[15]
  - crc <= {crc[14:0],0} ^ (fb ? CRC16_POLY : 0)
  - CRC7 uses the same form with cmd_i and crc7[6].
- Data FSM states: D_IDLE, D_EMIT, D_END, D_CHECK. A 4-bit counter cnt is used in D_EMIT and D_CHECK.
- D_IDLE:
  - dat_en_i&&clken_i updates the CRCs.
  - dat_emit_i -> D_EMIT, cnt=15.
  - Otherwise dat_check_i -> D_CHECK, cnt=15, dat_err_o cleared. If both requests arrive together, emit wins.
  - Requests are sampled every clk, independent of clken_i.
- D_EMIT:
  - dat_oe_o=1, dat_o[l]=crc16[l][15].
  - Each clken_i: every CRC shifts left with zero fill and cnt decrements. At cnt==0 -> D_END.
  - After the 16 shifts all CRCs read 0.
- D_END: dat_oe_o=1, dat_o=all ones; next clken_i -> D_IDLE.
- D_CHECK:
  - Each clken_i: dat_err_o[l] |= dat_i[l]^crc16[l][15], the CRCs shift with zero fill, cnt decrements.
  - On the 16th bit -> D_IDLE, and dat_chk_done_o pulses on the next clk.
  - dat_err_o holds until clr_i or the next check start.
- CMD FSM states: C_IDLE, C_EMIT, C_END, with a 3-bit counter set to 6.
  - Emission is the same as the data FSM: 7 CRC bits MSB first on cmd_o, then end bit 1.
  - No check mode.
- Busy rules:
  - dat_en_i / cmd_en_i and new requests are ignored while the respective FSM is busy.
  - The data and CMD FSMs are fully independent and may run concurrently.
- dat_oe_o and cmd_oe_o are registered state decodes: there is 1 clk latency from a request to oe high, and the first bit is valid before the first clken_i in EMIT.

Decomposition:
- Package sd_crc_pkg: CRC16_POLY/CRC7_POLY defaults, data and CMD state enums, and function crc_step(width, crc, bit, poly).
- Sub-module sd_crc_lane, instanced LANES times. It holds one CRC16 register with absorb/shift/compare and a sticky error flag.
- Both FSMs live in the top level.

Test Plan:
- LANES=4, 512 bytes of 0xFF absorbed on every lane (4096 bits per lane) -> crc16_o each lane = 16'h7FA1.
- Then dat_emit_i -> dat_oe_o for exactly 17 clken_i; dat_o bits = 0111_1111_1010_0001 then 1111 (end bit). Afterwards crc16_o=0 and dat_busy_o=0.
- CMD0 (40 00 00 00 00, 40 bits) absorbed -> crc7_o=7'h4A. cmd_emit_i -> cmd_o = 1001010 then 1, i.e. final byte 0x95. CMD17 with arg 0 -> 7'h2A.
- Receive path: absorb 0xFF data, then check with correct CRC on lanes 0,1,3 and lane 2 bit 5 flipped -> dat_chk_done_o one pulse, dat_err_o=4'b0100.
- clr_i asserted during D_EMIT at bit 8 -> next clk: busy=0, oe=0, all CRCs 0, no chk_done. dat_emit_i+dat_check_i together -> emit runs.
- clken_i held low mid-emission for 5 clks -> dat_o stable, cnt frozen. rst_i pulsed asynchronously mid-check -> all outputs 0 immediately.
